// File: rtl/vram_scanout.sv
// vram_scanout: reads one framebuffer from VRAM and streams it through a pixel FIFO
// with line-end/frame-end tags; reads are credit-limited so the FIFO never overflows.
module vram_scanout #(
   parameter int FB_WIDTH   = 320,
   parameter int FB_HEIGHT  = 240,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset_n_i,
   input  logic        start_i,
   input  logic [15:0] base_addr_i,
   output logic        vram_sel_o,
   output logic [15:0] vram_addr_o,
   input  logic        vram_grant_i,
   input  logic [15:0] vram_data_i,
   output logic [15:0] pixel_o,
   output logic        pixel_valid_o,
   input  logic        pixel_ready_i,
   output logic        line_end_o,
   output logic        frame_end_o,
   output logic        busy_o,
   output logic        done_o
);
   localparam int XW = $clog2(FB_WIDTH + 1);
   localparam int YW = $clog2(FB_HEIGHT + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [XW-1:0] X_LAST = XW'(FB_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(FB_HEIGHT - 1);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
   state_t state, state_nx;

   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [15:0]   addr;
   logic          rd_v, rd_le, rd_fe;
   logic [17:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wp, rp;
   logic [CW-1:0] cnt;
   logic [17:0]   head;
   logic          x_end, last, issue, pop;

   assign x_end         = x == X_LAST;
   assign last          = x_end && y == Y_LAST;
   // a pending read already owns a FIFO slot, so count it against the depth
   assign vram_sel_o    = state == FETCH && ({1'b0, cnt} + (CW + 1)'(rd_v)) < DEPTH_C;
   assign issue         = vram_sel_o && vram_grant_i;
   assign vram_addr_o   = addr;
   assign pixel_valid_o = cnt != '0;
   assign pop           = pixel_valid_o && pixel_ready_i;
   assign head          = pixel_valid_o ? mem[rp] : '0;
   assign pixel_o       = head[15:0];
   assign line_end_o    = head[16];
   assign frame_end_o   = head[17];
   assign busy_o        = state != IDLE;

   always_comb begin
      state_nx = state;
      if (state == IDLE && start_i) state_nx = FETCH;
      else if (state == FETCH && issue && last) state_nx = DRAIN;
      else if (state == DRAIN && pop && head[17]) state_nx = IDLE;
   end

   always_ff @(posedge clk) begin
      if (!reset_n_i) begin
         state  <= IDLE;
         x      <= '0;
         y      <= '0;
         addr   <= '0;
         rd_v   <= 1'b0;
         rd_le  <= 1'b0;
         rd_fe  <= 1'b0;
         wp     <= '0;
         rp     <= '0;
         cnt    <= '0;
         done_o <= 1'b0;
      end else begin
         state  <= state_nx;
         done_o <= pop && head[17];
         rd_v   <= issue;
         rd_le  <= x_end;
         rd_fe  <= last;
         if (state == IDLE && start_i) begin
            addr <= base_addr_i;
            x    <= '0;
            y    <= '0;
         end else if (issue) begin
            addr <= addr + 16'd1;
            x    <= x_end ? '0 : x + XW'(1);
            y    <= x_end ? y + YW'(1) : y;
         end
         if (rd_v) wp <= wp + AW'(1);
         if (pop) rp <= rp + AW'(1);
         cnt <= cnt + CW'(rd_v) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rd_v) mem[wp] <= {rd_fe, rd_le, vram_data_i};
   end
endmodule

// File: tb/tb_vram_scanout.sv
// tb_vram_scanout: randomized bench for vram_scanout; a frame-level model predicts the
// pixel stream and read addresses, a negedge monitor scores what the DUT delivers.
module tb_vram_scanout;
   localparam int W = 4, H = 2, D = 4, N = W * H;

   logic        clk = 0, reset_n_i = 0, start_i = 0, vram_grant_i = 1, pixel_ready_i = 1;
   logic [15:0] base_addr_i = 0, vram_data_i;
   logic        vram_sel_o, pixel_valid_o, line_end_o, frame_end_o, busy_o, done_o;
   logic [15:0] vram_addr_o, pixel_o;

   vram_scanout #(.FB_WIDTH(W), .FB_HEIGHT(H), .FIFO_DEPTH(D)) dut (
      .clk(clk), .reset_n_i(reset_n_i), .start_i(start_i), .base_addr_i(base_addr_i),
      .vram_sel_o(vram_sel_o), .vram_addr_o(vram_addr_o), .vram_grant_i(vram_grant_i),
      .vram_data_i(vram_data_i), .pixel_o(pixel_o), .pixel_valid_o(pixel_valid_o),
      .pixel_ready_i(pixel_ready_i), .line_end_o(line_end_o), .frame_end_o(frame_end_o),
      .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   logic [15:0] vram [65536];
   always @(posedge clk) vram_data_i <= vram[vram_addr_o];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0, n_fail = 0;
   logic [17:0] exp_q[$];
   logic [15:0] iss_addr[$];
   int          xfer_cyc[$];
   int          n_xfer, n_err, n_done, hold_viol, first_bad, done_cyc, s_cyc;
   logic [17:0] got, bad_got, bad_exp;
   logic        done_busy, last_xfer_busy, prev_stall;
   logic [15:0] prev_addr, cur_base;

   always @(negedge clk) begin
      if (!reset_n_i) prev_stall = 1'b0;
      else begin
         if (pixel_valid_o && pixel_ready_i) begin
            got = {frame_end_o, line_end_o, pixel_o};
            if (n_xfer >= exp_q.size() || got !== exp_q[n_xfer]) begin
               if (n_err == 0) begin
                  first_bad = n_xfer;
                  bad_got = got;
                  bad_exp = n_xfer < exp_q.size() ? exp_q[n_xfer] : 18'h0;
               end
               n_err++;
            end
            xfer_cyc.push_back(cyc);
            last_xfer_busy = busy_o;
            n_xfer++;
         end
         if (done_o) begin
            n_done++;
            done_cyc = cyc;
            done_busy = busy_o;
         end
         if (vram_sel_o && vram_grant_i) iss_addr.push_back(vram_addr_o);
         if (prev_stall && vram_addr_o !== prev_addr) hold_viol++;
         prev_stall = vram_sel_o && !vram_grant_i;
         prev_addr = vram_addr_o;
      end
   end

   task automatic new_frame(input logic [15:0] base);
      exp_q.delete();
      iss_addr.delete();
      xfer_cyc.delete();
      n_xfer = 0; n_err = 0; n_done = 0; hold_viol = 0; first_bad = -1;
      cur_base = base;
      for (int i = 0; i < N; i++)
         exp_q.push_back({i == N - 1, i % W == W - 1, vram[16'(int'(base) + i)]});
   endtask

   task automatic start_frame(input logic [15:0] base);
      new_frame(base);
      base_addr_i = base;
      start_i = 1;
      @(posedge clk); #1;
      start_i = 0;
      s_cyc = cyc;
   endtask

   task automatic finish_frame(input int gm, input int rm, input bit poke);
      for (int k = 0; k < 400 && n_done == 0; k++) begin
         vram_grant_i = (gm == 0) || (gm == 1 && k % 2 == 1) || (gm == 2 && $urandom_range(0, 1) == 1);
         pixel_ready_i = (rm == 0) || (rm == 2 && $urandom_range(0, 2) != 0);
         start_i = poke && n_xfer < 4 && $urandom_range(0, 1) == 1;
         @(posedge clk); #1;
      end
      start_i = 0;
      vram_grant_i = 1;
      pixel_ready_i = 1;
   endtask

   task automatic test_reset;
      reset_n_i = 0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({vram_sel_o, pixel_valid_o, line_end_o, frame_end_o, busy_o, done_o} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got sel/valid/le/fe/busy/done=%b expected 000000",
                  {vram_sel_o, pixel_valid_o, line_end_o, frame_end_o, busy_o, done_o});
      end
      n_checks++;
      if (vram_addr_o !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_addr: got %h expected 0000", vram_addr_o);
      end
      reset_n_i = 1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({vram_sel_o, pixel_valid_o, busy_o} !== 3'b0) begin
         n_fail++;
         $display("FAIL idle_hold: got sel/valid/busy=%b expected 000", {vram_sel_o, pixel_valid_o, busy_o});
      end
   endtask

   task automatic test_stream;
      vram_grant_i = 1;
      pixel_ready_i = 1;
      start_frame(16'h0100);
      finish_frame(0, 0, 0);
      n_checks++;
      if (n_err !== 0 || n_xfer !== N) begin
         n_fail++;
         $display("FAIL stream: %0d of %0d bad, first idx %0d got %h expected %h",
                  n_err, n_xfer, first_bad, bad_got, bad_exp);
      end
      n_checks++;
      if (n_done !== 1) begin
         n_fail++;
         $display("FAIL stream_done: got %0d pulses expected 1", n_done);
      end
      for (int i = 0; i < xfer_cyc.size(); i++) begin
         n_checks++;
         if (xfer_cyc[i] !== s_cyc + 2 + i) begin
            n_fail++;
            $display("FAIL stream_timing[%0d]: got cycle %0d expected %0d", i, xfer_cyc[i], s_cyc + 2 + i);
         end
      end
      n_checks++;
      if (done_cyc !== s_cyc + N + 2 || done_busy !== 1'b0 || last_xfer_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL done_timing: got cycle %0d busy %b/%b expected cycle %0d busy 1/0",
                  done_cyc, last_xfer_busy, done_busy, s_cyc + N + 2);
      end
   endtask

   task automatic test_backpressure;
      vram_grant_i = 1;
      pixel_ready_i = 0;
      start_frame(16'($urandom));
      repeat (12) @(posedge clk);
      #1;
      n_checks++;
      if (iss_addr.size() !== D || vram_sel_o !== 1'b0 || pixel_valid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_credit: got issues %0d sel %b valid %b expected %0d 0 1",
                  iss_addr.size(), vram_sel_o, pixel_valid_o, D);
      end
      finish_frame(0, 0, 0);
      n_checks++;
      if (n_err !== 0 || n_xfer !== N || n_done !== 1) begin
         n_fail++;
         $display("FAIL bp_stream: got bad %0d xfers %0d done %0d expected 0 %0d 1", n_err, n_xfer, n_done, N);
      end
   endtask

   task automatic test_grant_toggle;
      vram_grant_i = 1;
      pixel_ready_i = 1;
      start_frame(16'h0100);
      finish_frame(1, 0, 0);
      n_checks++;
      if (hold_viol !== 0) begin
         n_fail++;
         $display("FAIL grant_hold: got %0d address moves under grant=0 expected 0", hold_viol);
      end
      n_checks++;
      if (n_err !== 0 || n_xfer !== N || n_done !== 1 || iss_addr.size() !== N) begin
         n_fail++;
         $display("FAIL grant_stream: got bad %0d xfers %0d done %0d issues %0d expected 0 %0d 1 %0d",
                  n_err, n_xfer, n_done, iss_addr.size(), N, N);
      end
   endtask

   task automatic test_wrap;
      vram_grant_i = 1;
      pixel_ready_i = 1;
      start_frame(16'hFFFE);
      finish_frame(0, 0, 0);
      for (int i = 0; i < N; i++) begin
         n_checks++;
         if (i >= iss_addr.size() || iss_addr[i] !== 16'(32'hFFFE + i)) begin
            n_fail++;
            $display("FAIL wrap_addr[%0d]: got %h expected %h", i,
                     i < iss_addr.size() ? iss_addr[i] : 16'h0, 16'(32'hFFFE + i));
         end
      end
      n_checks++;
      if (n_err !== 0 || n_xfer !== N) begin
         n_fail++;
         $display("FAIL wrap_stream: got bad %0d xfers %0d expected 0 %0d", n_err, n_xfer, N);
      end
   endtask

   task automatic test_reset_mid;
      logic [15:0] b;
      b = 16'($urandom);
      vram_grant_i = 1;
      pixel_ready_i = 1;
      start_frame(b);
      for (int k = 0; k < 100 && n_xfer < 3; k++) begin
         @(posedge clk); #1;
      end
      reset_n_i = 0;
      @(posedge clk); #1;
      n_checks++;
      if ({vram_sel_o, pixel_valid_o, line_end_o, frame_end_o, busy_o, done_o} !== 6'b0 || vram_addr_o !== 16'h0) begin
         n_fail++;
         $display("FAIL midreset: got ctrl %b addr %h expected 000000 0000",
                  {vram_sel_o, pixel_valid_o, line_end_o, frame_end_o, busy_o, done_o}, vram_addr_o);
      end
      reset_n_i = 1;
      @(posedge clk); #1;
      n_checks++;
      if (pixel_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_discard: got valid %b expected 0", pixel_valid_o);
      end
      start_frame(b);
      finish_frame(0, 0, 0);
      n_checks++;
      if (n_err !== 0 || n_xfer !== N || n_done !== 1) begin
         n_fail++;
         $display("FAIL replay: got bad %0d xfers %0d done %0d expected 0 %0d 1", n_err, n_xfer, n_done, N);
      end
   endtask

   task automatic test_start_busy;
      vram_grant_i = 1;
      pixel_ready_i = 1;
      start_frame(16'($urandom));
      finish_frame(2, 2, 1);
      repeat (20) @(posedge clk);
      #1;
      n_checks++;
      if (n_done !== 1 || n_xfer !== N || n_err !== 0 || iss_addr.size() !== N || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL start_busy: got done %0d xfers %0d bad %0d issues %0d busy %b expected 1 %0d 0 %0d 0",
                  n_done, n_xfer, n_err, iss_addr.size(), busy_o, N, N);
      end
   endtask

   task automatic test_random;
      for (int f = 0; f < 6; f++) begin
         vram_grant_i = 1;
         pixel_ready_i = 1;
         start_frame(16'($urandom));
         finish_frame(2, 2, 0);
         n_checks++;
         if (n_err !== 0 || n_xfer !== N || n_done !== 1) begin
            n_fail++;
            $display("FAIL random[%0d] base %h: got bad %0d xfers %0d done %0d, first idx %0d got %h expected %h",
                     f, cur_base, n_err, n_xfer, n_done, first_bad, bad_got, bad_exp);
         end
         n_checks++;
         if (hold_viol !== 0 || iss_addr.size() !== N) begin
            n_fail++;
            $display("FAIL random_issue[%0d]: got holds %0d issues %0d expected 0 %0d", f, hold_viol, iss_addr.size(), N);
         end
      end
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) vram[a] = 16'($urandom);
      test_reset();
      test_stream();
      test_backpressure();
      test_grant_toggle();
      test_wrap();
      test_reset_mid();
      test_start_busy();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
